// File: rtl/sr_cmd_if.sv
// Request/flop-side bundle of the SR command driver: valid/ready command handshake,
// q feedback from the flop, s/r drive and status pulses.
interface sr_cmd_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic q_fb;
  logic s;
  logic r;
  logic busy;
  logic done;
  logic err;

  // controller side: issues commands, observes flop and status
  modport master (
    output req_valid, req_level, q_fb,
    input  req_ready, s, r, busy, done, err
  );

  // driver side: accepts commands, drives the flop, reports status
  modport slave (
    input  req_valid, req_level, q_fb,
    output req_ready, s, r, busy, done, err
  );
endinterface

// File: rtl/sr_cmd_driver.sv
// Drives one SR flop to a requested level with a dead-time/pulse/verify sequence and
// reports done or err. All outputs come straight from registers.
module sr_cmd_driver #(
  parameter int PULSE_CYC   = 2,
  parameter int DEAD_CYC    = 1,
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = 4
) (
  input logic     clk,
  input logic     rst,
  sr_cmd_if.slave bus
);

  localparam int MAX_CYC = (PULSE_CYC > DEAD_CYC) ?
                           ((PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC) :
                           ((DEAD_CYC > TIMEOUT_CYC) ? DEAD_CYC : TIMEOUT_CYC);

  if (PULSE_CYC < 1 || TIMEOUT_CYC < 1 || DEAD_CYC < 0) begin : g_bad_cyc
    $error("sr_cmd_driver: PULSE_CYC and TIMEOUT_CYC must be >= 1, DEAD_CYC >= 0");
  end
  if (MAX_CYC >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("sr_cmd_driver: CNT_W too narrow for the longest phase");
  end

  // Counter holds "cycles left in this phase minus one"; the phase ends when it is zero.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    PULSE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             s_r;
  logic             r_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             ready_r;

  // Sequencer: state, phase counter and every output register move together so that
  // outputs always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
      s_r     <= 1'b0;
      r_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            level_r <= bus.req_level;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
            if (bus.req_level == bus.q_fb) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (DEAD_CYC == 0) begin
              state_r <= PULSE;
              cnt_r   <= PULSE_LD;
              s_r     <= bus.req_level;
              r_r     <= ~bus.req_level;
            end else begin
              state_r <= DEAD;
              cnt_r   <= DEAD_LD;
            end
          end else begin
            state_r <= IDLE;
            s_r     <= 1'b0;
            r_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
          end
        end

        DEAD: begin
          if (cnt_r == '0) begin
            state_r <= PULSE;
            cnt_r   <= PULSE_LD;
            s_r     <= level_r;
            r_r     <= ~level_r;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        PULSE: begin
          if (cnt_r == '0) begin
            state_r <= CHECK;
            cnt_r   <= CHECK_LD;
            s_r     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        // q_fb is only looked at here; glitches during dead time or the pulse do not matter
        CHECK: begin
          if (bus.q_fb == level_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else if (cnt_r == '0) begin
            state_r <= ERR;
            err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        DONE, ERR: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          s_r     <= 1'b0;
          r_r     <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.s         = s_r;
  assign bus.r         = r_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule
